// File: rtl/pattern_stream_gen3393.sv
// Stimulus source for the 3393 pattern identifier: LFSR filler digits with
// the sequence 3,3,9,3 inserted after every GAP fillers, plus a golden hit flag.
module pattern_stream_gen3393 #(
    parameter int unsigned GAP  = 6,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] burst_len,
    output logic [8:0] data_out,
    output logic       valid,
    output logic       expect_hit,
    output logic       busy,
    output logic       done,
    output logic [7:0] pattern_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        P0   = 3'd2,
        P1   = 3'd3,
        P2   = 3'd4,
        P3   = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [15:0] GAP_LD = 16'(GAP);

    state_t      cur_state, nxt_state;
    logic [7:0]  rem_cnt, rem_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [7:0]  count_nxt;
    logic [8:0]  data_nxt;
    logic        valid_nxt, hit_nxt, busy_nxt, done_nxt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Fold 10..15 down and replace 3 by 4 so filler can never form a 3393.
    function automatic logic [3:0] filler_digit(input logic [15:0] l);
        logic [3:0] d;
        d = l[3:0];
        if (d >= 4'd10) d = d - 4'd10;
        if (d == 4'd3)  d = 4'd4;
        return d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            rem_cnt   <= '0;
            gap_cnt   <= '0;
            lfsr      <= SEED;
        end else begin
            cur_state <= nxt_state;
            rem_cnt   <= rem_nxt;
            gap_cnt   <= gap_nxt;
            lfsr      <= lfsr_nxt;
        end
    end

    // rem_cnt and gap_cnt count the digit being shown in the current cycle.
    always_comb begin
        nxt_state = cur_state;
        rem_nxt   = rem_cnt;
        gap_nxt   = gap_cnt;
        lfsr_nxt  = lfsr;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    rem_nxt  = burst_len;
                    gap_nxt  = GAP_LD;
                    lfsr_nxt = SEED;
                    if (burst_len == 8'd0)   nxt_state = DONE;
                    else if (GAP_LD != '0)   nxt_state = FILL;
                    else                     nxt_state = P0;
                end
            end
            FILL, P0, P1, P2, P3: begin
                rem_nxt = rem_cnt - 8'd1;
                if (cur_state == FILL) begin
                    lfsr_nxt = lfsr_step(lfsr);
                    gap_nxt  = gap_cnt - 16'd1;
                end
                if (stop) begin
                    nxt_state = IDLE;
                end else if (rem_cnt == 8'd1) begin
                    nxt_state = DONE;
                end else begin
                    case (cur_state)
                        FILL: nxt_state = (gap_cnt == 16'd1) ? P0 : FILL;
                        P0:   nxt_state = P1;
                        P1:   nxt_state = P2;
                        P2:   nxt_state = P3;
                        default: begin
                            gap_nxt   = GAP_LD;
                            nxt_state = (GAP_LD != '0) ? FILL : P0;
                        end
                    endcase
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in registers.
    always_comb begin
        data_nxt  = '0;
        valid_nxt = 1'b0;
        hit_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        count_nxt = pattern_count;
        case (nxt_state)
            FILL: data_nxt = {5'd0, filler_digit(lfsr_nxt)};
            P0:   data_nxt = 9'd3;
            P1:   data_nxt = 9'd3;
            P2:   data_nxt = 9'd9;
            P3:   data_nxt = 9'd3;
            DONE: done_nxt = 1'b1;
            default: data_nxt = '0;
        endcase
        if (nxt_state inside {FILL, P0, P1, P2, P3}) begin
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
        end
        if (nxt_state == P3) begin
            hit_nxt   = 1'b1;
            count_nxt = pattern_count + 8'd1;
        end
        if (cur_state == IDLE && start) count_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out      <= '0;
            valid         <= 1'b0;
            expect_hit    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pattern_count <= '0;
        end else begin
            data_out      <= data_nxt;
            valid         <= valid_nxt;
            expect_hit    <= hit_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            pattern_count <= count_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: doc/pattern_stream_gen3393.md
# pattern_stream_gen3393

Stimulus source for the '3393' pattern identifier. On a start pulse it emits a burst of digit values, one per clock. Filler digits come from an LFSR and are never 3. The sequence 3,3,9,3 is inserted after every GAP filler digits. A golden `expect_hit` flag is produced with the digit that completes each inserted pattern. The block drives the identifier's `data_in` directly, so benches and on-board demos can compare `hit` against `expect_hit`.

## Interface
- `GAP`, default 6: number of filler digits before each inserted pattern; 0 means patterns back-to-back.
- `SEED`, default 16'hACE1: LFSR load value; must be non-zero.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to begin a burst; honoured only in IDLE.
- `stop`  in  1: synchronous abort; honoured in FILL or P0–P3.
- `burst_len`  in  8: total digits in the burst; sampled on the accepted `start`.
- `data_out`  out  9: current digit, 0..9 zero-extended; connects to identifier `data_in`.
- `valid`  out  1: `data_out` holds a burst digit this cycle.
- `expect_hit`  out  1: this digit completes an inserted 3393.
- `busy`  out  1: FSM is in FILL or P0–P3.
- `done`  out  1: one-cycle pulse after a burst completes normally.
- `pattern_count`  out  8: completed patterns in the current or last burst; wraps at 255.
- `state`  out  3: FSM state code, for debug.

## Operation
- FSM states and codes:
  - IDLE = 0, FILL = 1, P0 = 2, P1 = 3, P2 = 4, P3 = 5, DONE = 6.
  - P0..P3 emit 3, 3, 9, 3 respectively.
- Accepted `start` in IDLE:
  - load the remaining-digit counter from `burst_len`, the gap counter from GAP, and the LFSR from SEED;
  - clear `pattern_count`;
  - go to FILL if GAP > 0, else P0;
  - if `burst_len` = 0, go to DONE instead.
- FILL:
  - emit one filler digit per cycle, advancing the LFSR once per filler digit;
  - after GAP filler digits, go to P0.
- P0→P1→P2→P3 advance one digit per cycle.
- P3:
  - assert `expect_hit` with the final 3 and increment `pattern_count`;
  - go to FILL, or to P0 if GAP = 0, with the gap counter reloaded.
- Every emitted digit decrements the remaining counter. After the digit that brings it to 0, go to DONE regardless of the current state.
  - A pattern truncated this way gets no `expect_hit` and no count.
- DONE: `done` = 1 for one cycle, then IDLE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.
  - Filler digit: d = lfsr[3:0]; if d ≥ 10 then d −= 10; if d = 3 then d = 4.
  - This guarantees no accidental 3393 in filler.
- `stop` while busy: go to IDLE next cycle.
  - `valid` and `expect_hit` drop; no `done`; `pattern_count` holds.
- `start` while not IDLE is ignored. `stop` in IDLE or DONE is ignored.
- `start` and `stop` together in IDLE: start wins.

## Timing
- Reset values:
  - `state` = IDLE, and `data_out`, `valid`, `expect_hit`, `busy`, `done`, `pattern_count` all 0;
  - LFSR = SEED.
- All outputs are registered.
- `start` high in cycle n → first digit with `valid` = 1 in cycle n+1.
- One digit per cycle with no bubbles; `valid` stays high for exactly `burst_len` consecutive cycles.
- `done` occurs in the cycle after the last valid digit.
- Latency for a burst of L > 0 digits: L+2 cycles from the `start` edge to the return to IDLE.
- When `valid` = 0, `data_out` = 0.
- `expect_hit` is only ever high together with `valid` and `data_out` = 3.
- `stop` in cycle n → `valid` = 0 in cycle n+1.
- Reset mid-burst: outputs return to reset values immediately (asynchronously); no `done`.

## Test plan
- GAP=2, `burst_len`=12 → stream F,F,3,3,9,3,F,F,3,3,9,3, where each F is in {0..9}\{3}.
  - `expect_hit` on digits 6 and 12; `pattern_count`=2; `done` in the cycle after digit 12.
- GAP=2, `burst_len`=5 → F,F,3,3,9.
  - No `expect_hit`; `pattern_count`=0; `done` pulses.
- GAP=0, `burst_len`=8 → 3,3,9,3,3,3,9,3.
  - `expect_hit` on digits 4 and 8; `pattern_count`=2.
- `burst_len`=0 → `done` in cycle n+1; `valid` never asserted; `pattern_count`=0.
- GAP=6, `burst_len`=40, `stop` at digit 15 → `valid` low next cycle, no `done`, `pattern_count`=1.
  - A second `start` with the same settings reproduces the identical first 14 digits, since the LFSR reloads SEED.
- `rst_n` low at digit 7 of a burst → all outputs 0 at once; FSM stays in IDLE until a new `start`.
  - A `start` pulse held during reset is ignored.
